// File: rtl/nf10_axis_pkg.sv
// Shared NetFPGA-10G AXI-Stream definitions: tuser field positions,
// splitter FSM encoding and a constant log2 helper.
package nf10_axis_pkg;

    localparam int DST_PORT_POS = 24;
    localparam int SRC_PORT_POS = 16;
    localparam int LEN_POS      = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        DROP   = 2'd2
    } splitter_state_t;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nf10_output_splitter_if.sv
// AXI4-Stream bundle used on both sides of the output splitter.
interface nf10_output_splitter_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: a word written on one edge is on dout
// right after that edge; nearly_full leaves exactly one free slot.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_LEVEL        = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_FULL_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [MAX_DEPTH_BITS:0]   count_reg;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (count_reg == FULL_LEVEL);
    assign empty       = (count_reg == '0);
    assign nearly_full = (count_reg >= NEARLY_FULL_LEVEL);
    assign do_wr       = wr_en & ~full;
    assign do_rd       = rd_en & ~empty;
    assign dout        = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/nf10_output_splitter_ctrl.sv
// Packet steering control: locks the destination bitmap for the length of a
// packet, gates input ready on the selected FIFOs and counts dropped packets.
module nf10_splitter_ctrl
    import nf10_axis_pkg::*;
#(
    parameter int NUM_QUEUES = 5
) (
    input  logic                  axi_aclk,
    input  logic                  axi_resetn,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic [NUM_QUEUES-1:0] bitmap,
    input  logic [NUM_QUEUES-1:0] nearly_full,
    output logic                  s_tready,
    output logic [NUM_QUEUES-1:0] wr_en,
    output logic [15:0]           drop_count
);
    splitter_state_t       state_reg;
    logic [NUM_QUEUES-1:0] dst_reg;
    logic [NUM_QUEUES-1:0] sel;
    logic                  xfer;

    // Only the first word steers; later words follow the locked bitmap.
    assign sel      = (state_reg == IDLE)   ? bitmap  :
                      (state_reg == WR_PKT) ? dst_reg : '0;
    assign s_tready = axi_resetn & ~|(sel & nearly_full);
    assign xfer     = s_tvalid & s_tready;
    assign wr_en    = {NUM_QUEUES{xfer}} & sel;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_reg  <= IDLE;
            dst_reg    <= '0;
            drop_count <= '0;
        end else if (xfer) begin
            case (state_reg)
                IDLE: begin
                    if (bitmap == '0) begin
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        if (!s_tlast) begin
                            state_reg <= DROP;
                        end
                    end else if (!s_tlast) begin
                        state_reg <= WR_PKT;
                        dst_reg   <= bitmap;
                    end
                end
                WR_PKT: begin
                    if (s_tlast) begin
                        state_reg <= IDLE;
                        dst_reg   <= '0;
                    end
                end
                DROP: begin
                    if (s_tlast) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/nf10_output_splitter.sv
// 1-to-5 AXI4-Stream packet splitter: each packet goes to every port set in its
// tuser destination bitmap through a per-port fallthrough FIFO.
module nf10_output_splitter
    import nf10_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 5,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                          axi_aclk,
    input  logic                          axi_resetn,
    nf10_output_splitter_if.slave         s_axis,
    nf10_output_splitter_if.master        m_axis_0,
    nf10_output_splitter_if.master        m_axis_1,
    nf10_output_splitter_if.master        m_axis_2,
    nf10_output_splitter_if.master        m_axis_3,
    nf10_output_splitter_if.master        m_axis_4,
    output logic [15:0]                   drop_count
);
    localparam int IN_WIDTH  = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + 1;
    localparam int OUT_WIDTH = C_M_AXIS_DATA_WIDTH + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH / 8 + 1;

    logic [IN_WIDTH-1:0]   fifo_din;
    logic [OUT_WIDTH-1:0]  fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] wr_en;
    logic [NUM_QUEUES-1:0] rd_en;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] nearly_full;
    logic [NUM_QUEUES-1:0] m_tready;
    logic                  fifo_reset;

    assign fifo_reset = ~axi_resetn;
    assign fifo_din   = {s_axis.tlast, s_axis.tstrb, s_axis.tuser, s_axis.tdata};

    nf10_splitter_ctrl #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_ctrl (
        .axi_aclk    (axi_aclk),
        .axi_resetn  (axi_resetn),
        .s_tvalid    (s_axis.tvalid),
        .s_tlast     (s_axis.tlast),
        .bitmap      (s_axis.tuser[DST_PORT_POS +: NUM_QUEUES]),
        .nearly_full (nearly_full),
        .s_tready    (s_axis.tready),
        .wr_en       (wr_en),
        .drop_count  (drop_count)
    );

    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
            assign rd_en[gi] = ~empty[gi] & m_tready[gi];

            fallthrough_small_fifo #(
                .WIDTH          (IN_WIDTH),
                .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_fifo (
                .clk         (axi_aclk),
                .reset       (fifo_reset),
                .din         (fifo_din),
                .wr_en       (wr_en[gi]),
                .rd_en       (rd_en[gi]),
                .dout        (fifo_dout[gi]),
                .nearly_full (nearly_full[gi]),
                .empty       (empty[gi])
            );
        end
    endgenerate

    // The port list is fixed at five outputs, so the FIFO array is unpacked by hand.
    assign {m_axis_0.tlast, m_axis_0.tstrb, m_axis_0.tuser, m_axis_0.tdata} = fifo_dout[0];
    assign m_axis_0.tvalid = ~empty[0];
    assign m_tready[0]     = m_axis_0.tready;

    assign {m_axis_1.tlast, m_axis_1.tstrb, m_axis_1.tuser, m_axis_1.tdata} = fifo_dout[1];
    assign m_axis_1.tvalid = ~empty[1];
    assign m_tready[1]     = m_axis_1.tready;

    assign {m_axis_2.tlast, m_axis_2.tstrb, m_axis_2.tuser, m_axis_2.tdata} = fifo_dout[2];
    assign m_axis_2.tvalid = ~empty[2];
    assign m_tready[2]     = m_axis_2.tready;

    assign {m_axis_3.tlast, m_axis_3.tstrb, m_axis_3.tuser, m_axis_3.tdata} = fifo_dout[3];
    assign m_axis_3.tvalid = ~empty[3];
    assign m_tready[3]     = m_axis_3.tready;

    assign {m_axis_4.tlast, m_axis_4.tstrb, m_axis_4.tuser, m_axis_4.tdata} = fifo_dout[4];
    assign m_axis_4.tvalid = ~empty[4];
    assign m_tready[4]     = m_axis_4.tready;
endmodule
